pwm_capture: RTL and testbench

Measures an incoming PWM waveform, the receive-side counterpart of the team's PWM generators. Reports raw high time and period in system clocks, plus duty in whole percent and frequency in Hz. Sits between a pin (servo feedback, fan tach, loopback of `pwm_controller` output) and control logic that consumes `duty`/`freq` after a `valid` pulse.

---
 rtl/pwm_capture_pkg.sv | 13 +
 rtl/pwm_capture_seq_divider.sv | 46 ++++
 rtl/pwm_capture.sv | 116 +++++++++++
 tb/tb_pwm_capture.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg: shared constants, clock-rate math and capture FSM encoding
package pwm_capture_pkg;
  localparam int CNT_W = 27;
  localparam int DIV_W = 34;
  localparam int FREQ_MAX = 65535;
  typedef enum logic [1:0] {IDLE, HIGH, LOW} cap_state_t;
  function automatic int real_sys_freq(input int sys_freq);
    return sys_freq * 1000 * 1000;
  endfunction
  function automatic int timeout_clks(input int sys_freq);
    return real_sys_freq(sys_freq);
  endfunction
endpackage

// File: rtl/pwm_capture_seq_divider.sv
// seq_divider: restoring divider producing one quotient bit per clock
module seq_divider #(
  parameter int DW = 34,
  parameter int VW = 27
) (
  input  logic          clk,
  input  logic          reset_p,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic          busy,
  output logic          done
);
  localparam int NW = $clog2(DW + 1);
  logic [DW-1:0] q;
  logic [VW-1:0] r, d;
  logic [NW-1:0] n;
  logic [VW:0] sh;
  logic ge;
  assign sh = {r, q[DW-1]};
  assign ge = sh >= {1'b0, d};
  assign done = busy && n == '0;
  assign quotient = q;
  // load on start (also in the result cycle so passes chain), else shift/subtract one bit
  always_ff @(posedge clk or posedge reset_p)
    if (reset_p) begin
      q <= '0;
      r <= '0;
      d <= '0;
      n <= '0;
      busy <= 1'b0;
    end else if (start && (!busy || done)) begin
      q <= dividend;
      r <= '0;
      d <= divisor;
      n <= NW'(DW);
      busy <= 1'b1;
    end else if (done) begin
      busy <= 1'b0;
    end else if (busy) begin
      q <= {q[DW-2:0], ge};
      r <= VW'(ge ? sh - {1'b0, d} : sh);
      n <= n - NW'(1);
    end
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an async PWM input, derives duty and frequency
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int SYS_FREQ = 125,
  parameter int TIMEOUT  = timeout_clks(SYS_FREQ)
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic [6:0]       duty,
  output logic [15:0]      freq,
  output logic             valid,
  output logic             no_signal
);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TO_SAT = CNT_W'(TIMEOUT);
  localparam logic [DIV_W-1:0] REAL_F = DIV_W'(real_sys_freq(SYS_FREQ));
  localparam logic [DIV_W-1:0] F_MAX = DIV_W'(FREQ_MAX);
  localparam logic [15:0] F_SAT = 16'(FREQ_MAX);
  cap_state_t state, state_n;
  logic s1, s2, s3, rise, fall;
  logic [CNT_W-1:0] cnt, high_rec, per_lat;
  logic [6:0] duty_q;
  logic restart, rec_high, snap, timeout, pass;
  logic div_start, div_busy, div_done;
  logic [DIV_W-1:0] div_dividend, quotient;
  logic [CNT_W-1:0] div_divisor;
  // two-flop synchronizer plus edge-detect flop; rise/fall are registered one-cycle flags
  always_ff @(posedge clk or posedge reset_p)
    if (reset_p) begin
      {s1, s2, s3} <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      {s1, s2, s3} <= {pwm_in, s1, s2};
      rise <= s2 & ~s3;
      fall <= ~s2 & s3;
    end
  // a rise can never coincide with the last count before timeout in HIGH, so rise simply wins
  assign timeout = cnt == TO_LAST && !rise;
  // capture FSM state register
  always_ff @(posedge clk or posedge reset_p)
    if (reset_p) state <= IDLE;
    else state <= state_n;
  // next state: a timeout from anywhere parks the FSM in IDLE
  always_comb
    state_n = timeout ? IDLE :
              state == IDLE ? (rise ? HIGH : IDLE) :
              state == HIGH ? (fall ? LOW : HIGH) :
              state == LOW ? (rise ? HIGH : LOW) : IDLE;
  // FSM-decoded datapath strobes
  always_comb begin
    restart = state == IDLE && rise;
    rec_high = state == HIGH && fall;
    snap = state == LOW && rise;
  end
  // period counter saturates at the timeout value so the timeout fires once until the next rise
  always_ff @(posedge clk or posedge reset_p)
    if (reset_p) begin
      cnt <= '0;
      high_rec <= '0;
      high_cnt <= '0;
      period_cnt <= '0;
    end else begin
      cnt <= (restart || snap) ? CNT_W'(1) : cnt == TO_SAT ? cnt : cnt + CNT_W'(1);
      if (rec_high) high_rec <= cnt;
      if (snap) begin
        high_cnt <= high_rec;
        period_cnt <= cnt;
      end
    end
  // duty pass starts straight off the snapshot; the freq pass chains in the duty pass result cycle
  assign div_start = (snap && !div_busy) || (div_done && !pass);
  assign div_dividend = div_busy ? REAL_F : DIV_W'(high_rec) * DIV_W'(100);
  assign div_divisor = div_busy ? per_lat : cnt;
  seq_divider #(.DW(DIV_W), .VW(CNT_W)) u_div (
    .clk      (clk),
    .reset_p  (reset_p),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .quotient (quotient),
    .busy     (div_busy),
    .done     (div_done)
  );
  // result registers: timeout publishes the constant-level result, else publish after the freq pass
  always_ff @(posedge clk or posedge reset_p)
    if (reset_p) begin
      pass <= 1'b0;
      per_lat <= '0;
      duty_q <= '0;
      duty <= '0;
      freq <= '0;
      valid <= 1'b0;
      no_signal <= 1'b1;
    end else begin
      valid <= 1'b0;
      if (div_start) pass <= div_busy;
      if (div_start && !div_busy) per_lat <= cnt;
      if (div_done && !pass) duty_q <= quotient[6:0];
      if (restart) no_signal <= 1'b0;
      if (timeout) begin
        duty <= s3 ? 7'd100 : 7'd0;
        freq <= '0;
        valid <= 1'b1;
        no_signal <= 1'b1;
      end else if (div_done && pass) begin
        duty <= duty_q;
        freq <= quotient > F_MAX ? F_SAT : quotient[15:0];
        valid <= 1'b1;
      end
    end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: PWM stimulus checked against a period-level reference model
module tb_pwm_capture;
  localparam int SYS_FREQ = 10;
  localparam int TO = 15000;
  localparam longint RF = 64'(SYS_FREQ) * 1000000;
  typedef struct packed {
    logic [26:0] h;
    logic [26:0] p;
    logic [6:0]  d;
    logic [15:0] f;
    logic        ns;
  } rec_t;
  logic clk = 1'b0;
  logic reset_p, pwm_in;
  logic [26:0] high_cnt, period_cnt;
  logic [6:0] duty;
  logic [15:0] freq;
  logic valid, no_signal;
  int npass = 0;
  int ntot = 0;
  rec_t obs_q[$];
  rec_t exp_q[$];
  bit have_prev;
  int prev_h, prev_p, last_h, last_p;

  pwm_capture #(.SYS_FREQ(SYS_FREQ), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset_p    (reset_p),
    .pwm_in     (pwm_in),
    .high_cnt   (high_cnt),
    .period_cnt (period_cnt),
    .duty       (duty),
    .freq       (freq),
    .valid      (valid),
    .no_signal  (no_signal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rec_t r;
    #1;
    if (valid === 1'b1) begin
      r = '{high_cnt, period_cnt, duty, freq, no_signal};
      obs_q.push_back(r);
    end
  end

  function automatic rec_t period_result(input int h, input int p);
    longint f;
    rec_t r;
    f = RF / p;
    r.h = 27'(h);
    r.p = 27'(p);
    r.d = 7'(h * 100 / p);
    r.f = 16'(f > 65535 ? 65535 : f);
    r.ns = 1'b0;
    return r;
  endfunction

  task automatic rise_model(input int h, input int p);
    if (have_prev) begin
      exp_q.push_back(period_result(prev_h, prev_p));
      last_h = prev_h;
      last_p = prev_p;
    end
    have_prev = 1;
    prev_h = h;
    prev_p = p;
  endtask

  task automatic timeout_model(input bit level);
    rec_t r;
    r = '{27'(last_h), 27'(last_p), level ? 7'd100 : 7'd0, 16'd0, 1'b1};
    exp_q.push_back(r);
    have_prev = 0;
  endtask

  task automatic pulse(input int h, input int p);
    rise_model(h, p);
    pwm_in = 1'b1;
    repeat (h) @(negedge clk);
    pwm_in = 1'b0;
    repeat (p - h) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_q(input string tag);
    chk({tag, " valid count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      ntot++;
      assert (obs_q[i] === exp_q[i]) npass++;
      else $error("FAIL %s[%0d]: observed h=%0d p=%0d duty=%0d freq=%0d ns=%0d expected h=%0d p=%0d duty=%0d freq=%0d ns=%0d",
                  tag, i, obs_q[i].h, obs_q[i].p, obs_q[i].d, obs_q[i].f, obs_q[i].ns,
                  exp_q[i].h, exp_q[i].p, exp_q[i].d, exp_q[i].f, exp_q[i].ns);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " duty"}, 64'(duty), 0);
    chk({tag, " freq"}, 64'(freq), 0);
    chk({tag, " high_cnt"}, 64'(high_cnt), 0);
    chk({tag, " period_cnt"}, 64'(period_cnt), 0);
    chk({tag, " valid"}, 64'(valid), 0);
    chk({tag, " no_signal"}, 64'(no_signal), 1);
  endtask

  initial begin
    int h, p;
    have_prev = 0;
    last_h = 0;
    last_p = 0;
    reset_p = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    reset_p = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset");
    repeat (20) @(negedge clk);
    repeat (3) pulse(50, 100);
    repeat (3) pulse(100, 1000);
    repeat (2) pulse(700, 10000);
    for (int i = 0; i < 10; i++) begin
      p = int'($urandom_range(100, 1500));
      h = int'($urandom_range(1, p - 1));
      pulse(h, p);
    end
    chk("running no_signal", 64'(no_signal), 0);
    pwm_in = 1'b1;
    rise_model(0, 0);
    timeout_model(1'b1);
    repeat (TO + 300) @(negedge clk);
    chk_q("run+high timeout");
    chk("high timeout no_signal", 64'(no_signal), 1);
    pwm_in = 1'b0;
    repeat (50) @(negedge clk);
    pulse(250, 500);
    chk("resume no_signal", 64'(no_signal), 0);
    chk("resume first period valids", 64'(obs_q.size()), 0);
    repeat (3) pulse(250, 500);
    timeout_model(1'b0);
    repeat (TO + 300) @(negedge clk);
    chk_q("resume+low timeout");
    chk("low timeout no_signal", 64'(no_signal), 1);
    repeat (3) pulse(20, 400);
    pwm_in = 1'b1;
    repeat (20) @(negedge clk);
    pwm_in = 1'b0;
    repeat (10) @(negedge clk);
    reset_p = 1'b1;
    repeat (2) @(negedge clk);
    reset_p = 1'b0;
    chk_q("pre-reset");
    chk_reset_outputs("mid-division reset");
    repeat (100) @(negedge clk);
    chk("aborted division valids", 64'(obs_q.size()), 0);
    have_prev = 0;
    last_h = 0;
    last_p = 0;
    repeat (3) pulse(30, 300);
    pwm_in = 1'b1;
    rise_model(0, 0);
    repeat (200) @(negedge clk);
    chk_q("post-reset");
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
